seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (>=2).
REQ-002 Parameter AMT_W, default 2, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request; sampled only when busy=0.
REQ-006 Port op  input  3  operation code, latched with start.
REQ-007 Port amt  input  AMT_W  shift count 0..WIDTH-1, latched with start.
REQ-008 Port data_in  input  WIDTH  operand, latched with start.
REQ-009 Port busy  output  1  high while shifting; start ignored.
REQ-010 Port done  output  1  one-cycle pulse, result valid.
REQ-011 Port data_out  output  WIDTH  result register, held until next completion.

Function
REQ-012 op encodings: 0 LSL, 1 LSR, 2 ASL (identical to LSL), 3 ASR (sign bit replicated), 4 ROL, 5 ROR, 6/7 reserved.
REQ-013 FSM states IDLE, SHIFT, DONE; busy = (state==SHIFT); done = (state==DONE).
REQ-014 IDLE or DONE with start=1: latch data_in/op/amt into working reg/op reg/counter; next state SHIFT if amt!=0 and op not reserved, else DONE.
REQ-015 IDLE or DONE with start=0: next state IDLE.
REQ-016 SHIFT: each edge applies exactly one single-position step of latched op to working reg and decrements counter; when counter==1 next state DONE.
REQ-017 Latency: start sampled at edge E0 -> done high in cycle after edge E(amt) (amt=0: cycle after E0); done high exactly one cycle.
REQ-018 Reserved op: zero steps regardless of amt; data_out = latched data_in; done after E0.
REQ-019 data_out loaded from the final working value on the edge entering DONE; unchanged at all other times; intermediate values never visible.
REQ-020 start while busy=1: ignored, no effect on state, counter or latched operands.
REQ-021 start in DONE cycle: accepted (back-to-back), done deasserts next cycle unless new amt=0.
REQ-022 amt latched as unsigned; no wrap beyond WIDTH-1 possible by width.

Reset
REQ-023 rst=1 at an edge: state IDLE, busy=0, done=0, data_out=0, counter=0, working reg=0; overrides start.
REQ-024 rst mid-SHIFT aborts operation; no done pulse for aborted request; data_out=0.

Structure
REQ-025 Package shift_pkg SHALL hold op encodings (OP_LSL..OP_ROR) and FSM state typedef.
REQ-026 One combinational sub-module shift_step (WIDTH param, op, word in -> word shifted one position) SHALL implement the per-cycle step.

Verification
REQ-027 data_in=1011, op=ASR, amt=1 -> done in cycle after E1, data_out=1101.
REQ-028 data_in=1011, op=LSL, amt=3 -> busy 3 cycles, done after E3, data_out=1000; LSR amt=2 -> 0010.
REQ-029 data_in=1011, op=ROR, amt=3 -> data_out=0111; ROL amt=1 -> 0111; data_in=1000 ASR amt=3 -> 1111.
REQ-030 amt=0 or op=6 with data_in=0110 -> busy never high, done after E0, data_out=0110.
REQ-031 start pulsed with different operands while busy -> ignored, first result unchanged; start in DONE cycle -> second result correct.
REQ-032 rst asserted mid-SHIFT (LSL amt=3, after E1) -> next cycle IDLE, busy=0, no done pulse, data_out=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASL = 3'd2,
        OP_ASR = 3'd3,
        OP_ROL = 3'd4,
        OP_ROR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Codes 6 and 7 have bit pattern 11x and perform no steps.
    function automatic logic op_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate of one word by the given op.
import shift_pkg::*;

module shift_step #(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_LSL, OP_ASL: dout = {din[WIDTH-2:0], 1'b0};
            OP_LSR:         dout = {1'b0, din[WIDTH-1:1]};
            OP_ASR:         dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROL:         dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OP_ROR:         dout = {din[0], din[WIDTH-1:1]};
            default:        dout = din;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one single-position step per clock, result published on entry to DONE.
import shift_pkg::*;

module seq_shifter #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_q),
        .din  (work_q),
        .dout (step_out)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d    = ST_DONE;
                    data_out_d = step_out;
                end
            end
            default: begin
                if (start) begin
                    work_d = data_in;
                    op_d   = op;
                    cnt_d  = amt;
                    // Zero-step requests complete immediately with the operand untouched.
                    if (amt != '0 && !op_reserved(op)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d    = ST_DONE;
                        data_out_d = data_in;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, per-op results, reserved/zero amt, busy-ignore, back-to-back, reset.
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [1:0] amt = '0;
    logic [3:0] data_in = '0;
    logic       busy;
    logic       done;
    logic [3:0] data_out;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_out = '0;

    seq_shifter #(.WIDTH(4), .AMT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .amt      (amt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion: busy for `steps` cycles, then a one-cycle done.
    task automatic do_op(input logic [3:0] d, input logic [2:0] o, input logic [1:0] a,
                         input int steps, input logic [3:0] exp, input string name);
        data_in = d; op = o; amt = a; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < steps; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || data_out !== exp_out) begin
                errors++;
                $display("FAIL %s shifting cycle %0d: busy=%b done=%b data_out=%b, expected busy=1 done=0 data_out=%b",
                         name, k, busy, done, data_out, exp_out);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== exp) begin
            errors++;
            $display("FAIL %s result: done=%b busy=%b data_out=%b, expected done=1 busy=0 data_out=%b",
                     name, done, busy, data_out, exp);
        end
        exp_out = exp;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || data_out !== exp_out) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b data_out=%b, expected done=0 busy=0 data_out=%b",
                     name, done, busy, data_out, exp_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = 4'b1011; op = 3'd0; amt = 2'd2;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset state: busy=%b done=%b data_out=%b, expected 0 0 0000", busy, done, data_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 4'b0000) begin
            errors++;
            $display("FAIL idle after reset: busy=%b done=%b data_out=%b, expected 0 0 0000", busy, done, data_out);
        end
        exp_out = 4'b0000;
    endtask

    task automatic test_ops();
        do_op(4'b1011, 3'd3, 2'd1, 1, 4'b1101, "asr1");
        do_op(4'b1011, 3'd0, 2'd3, 3, 4'b1000, "lsl3");
        do_op(4'b1011, 3'd1, 2'd2, 2, 4'b0010, "lsr2");
        do_op(4'b1011, 3'd5, 2'd3, 3, 4'b0111, "ror3");
        do_op(4'b1011, 3'd4, 2'd1, 1, 4'b0111, "rol1");
        do_op(4'b1000, 3'd3, 2'd3, 3, 4'b1111, "asr3_sign");
        do_op(4'b1001, 3'd2, 2'd1, 1, 4'b0010, "asl1");
        do_op(4'b1001, 3'd4, 2'd2, 2, 4'b0110, "rol2");
    endtask

    task automatic test_zero_steps();
        do_op(4'b0110, 3'd0, 2'd0, 0, 4'b0110, "amt0");
        do_op(4'b0110, 3'd6, 2'd3, 0, 4'b0110, "op6");
        do_op(4'b1001, 3'd7, 2'd2, 0, 4'b1001, "op7");
    endtask

    task automatic test_back_to_back();
        // Start LSL 1011 by 3, then try to disturb it while busy.
        data_in = 4'b1011; op = 3'd0; amt = 2'd3; start = 1'b1;
        tick();
        data_in = 4'b0110; op = 3'd5; amt = 2'd1;
        tick();
        data_in = 4'b1111; op = 3'd1; amt = 2'd0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || data_out !== exp_out) begin
            errors++;
            $display("FAIL ignore_while_busy: busy=%b done=%b data_out=%b, expected busy=1 done=0 data_out=%b",
                     busy, done, data_out, exp_out);
        end
        tick();
        checks++;
        if (done !== 1'b1 || data_out !== 4'b1000) begin
            errors++;
            $display("FAIL ignored_result: done=%b data_out=%b, expected done=1 data_out=1000", done, data_out);
        end
        // Accept a new request in the DONE cycle.
        data_in = 4'b1011; op = 3'd3; amt = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || data_out !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b data_out=%b, expected done=0 busy=1 data_out=1000",
                     done, busy, data_out);
        end
        tick();
        checks++;
        if (done !== 1'b1 || data_out !== 4'b1101) begin
            errors++;
            $display("FAIL b2b_result: done=%b data_out=%b, expected done=1 data_out=1101", done, data_out);
        end
        // amt=0 in the DONE cycle keeps done high for another cycle.
        data_in = 4'b0011; op = 3'd0; amt = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_amt0: done=%b busy=%b data_out=%b, expected done=1 busy=0 data_out=0011",
                     done, busy, data_out);
        end
        tick();
        exp_out = 4'b0011;
    endtask

    task automatic test_reset_mid_shift();
        data_in = 4'b1011; op = 3'd0; amt = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_shift: busy=%b done=%b data_out=%b, expected 0 0 0000", busy, done, data_out);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || data_out !== 4'b0000) begin
                errors++;
                $display("FAIL reset_no_done cycle %0d: busy=%b done=%b data_out=%b, expected 0 0 0000",
                         k, busy, done, data_out);
            end
        end
        exp_out = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
